prci_rst_seq: RTL and testbench
===============================

// Module: prci_rst_seq
// PURPOSE
//  Power/reset sequencer and PRCI register bank. Generates the SoC reset
//  domains in a fixed order: debug, DDR, cores/system. Releases o_sys_nrst
//  only after PLL lock and DDR calibration. Re-sequences on debug
//  ndmreset, software request or PLL lock loss.
//  APB slave on the PRCI bus1 slot. Reset only by i_nrst, so its registers
//  survive every sequenced reset.
// PARAMETERS
//  lock_filter   8   consecutive synced-lock cycles before lock is accepted
//  dbg_hold      4   cycles between dbg release and ddr release
//  sys_hold      16  cycles o_sys_nrst is held low after any re-sequence cause
// PORTS
//  i_clk        in   1    system clock; the only clock
//  i_nrst       in   1    power-on reset; asynchronous, active-low
//  i_mapinfo    in   mapinfo_type  APB slot address map
//  o_cfg        out  dev_config_type  PnP descriptor
//  i_apbi       in   apb_in_type   APB request
//  o_apbo       out  apb_out_type  APB response
//  i_pll_locked in   1    raw PLL lock, asynchronous to i_clk
//  i_ddr_calib  in   1    DDR PHY calibration done, synchronous
//  i_dmreset    in   1    ndmreset level from the debug module
//  o_dbg_nrst   out  1    debug-domain reset, active-low
//  o_ddr_nrst   out  1    DDR-domain reset, active-low
//  o_sys_nrst   out  1    core/bus reset, active-low
// BEHAVIOUR
//  Reset values
//   - All three nrst outputs 0.
//   - FSM state = WAIT_LOCK; counters 0.
//   - cause = 4'b0001 (POR).
//   - o_apbo.pready = 0, prdata = 0, pslverr = 0.
//  Lock input
//   - i_pll_locked passes a 2-FF synchroniser.
//   - lock_ok is set after lock_filter consecutive high synced samples.
//   - lock_ok clears on the first low synced sample.
//  FSM (all outputs registered)
//   - WAIT_LOCK -> DBG_REL when lock_ok.
//   - DBG_REL: o_dbg_nrst=1; counts dbg_hold cycles -> DDR_REL.
//   - DDR_REL: o_ddr_nrst=1 -> WAIT_CAL.
//   - WAIT_CAL -> SYS_HOLD when i_ddr_calib=1. There is no timeout.
//   - SYS_HOLD: counts sys_hold cycles -> RUN.
//   - RUN: o_sys_nrst=1.
//   - RUN -> SYS_HOLD on i_dmreset=1 or SW request: o_sys_nrst=0 next
//     cycle; dbg and ddr are untouched.
//   - Any state -> WAIT_LOCK on lock_ok falling: all three nrst=0 next
//     cycle. This has the highest priority.
//  Boundary rules
//   - i_dmreset held high in SYS_HOLD keeps reloading the counter: release
//     comes sys_hold cycles after dmreset falls.
//   - SW request outside RUN: the cause bit is set; no extra action.
//   - dmreset and SW request in the same cycle: both cause bits set; one
//     re-sequence.
//  APB
//   - Setup phase: psel=1, penable=0.
//   - Access is registered: pready=1 for exactly one cycle, in the cycle
//     after psel & penable (one wait state).
//   - pslverr is always 0.
//   - Decode uses paddr[4:2]. Unmapped offsets read 0; writes to them are
//     ignored.
//  Register map
//   - 0x00 STATUS RO: [0] lock_ok, [1] i_ddr_calib, [2] o_dbg_nrst,
//     [3] o_ddr_nrst, [4] o_sys_nrst, [10:8] FSM state.
//   - 0x04 SWRST WO: writing bit0=1 raises a one-cycle SW request.
//     Reads as 0.
//   - 0x08 CAUSE W1C: [0] POR, [1] dmreset, [2] SW, [3] lock loss.
//     A hardware set in the same cycle as a W1C clear of that bit wins.
//  Misc
//   - o_cfg is constant; vendor/device come from the package.
// STRUCTURE
//  prci_pkg holds:
//   - the state enum: WAIT_LOCK, DBG_REL, DDR_REL, WAIT_CAL, SYS_HOLD, RUN;
//   - register offsets and CAUSE bit indices;
//   - the PnP device id.
//  Sub-module prci_lock_filter: synchroniser plus lock_filter counter,
//   outputs lock_ok.
//  Everything else lives in one registered always_ff/always_comb pair.
// TESTING
//  1. POR; lock high at cycle 5; calib high at cycle 40.
//     -> dbg release at cycle 5+2+8+1; ddr release 4 cycles later;
//        sys release 16 cycles after calib; CAUSE=0x1.
//  2. In RUN, i_dmreset high for 3 cycles.
//     -> o_sys_nrst low next cycle, high 16 cycles after dmreset falls;
//        dbg/ddr stay 1; CAUSE[1]=1.
//  3. In RUN, APB write 0x04=0x1.
//     -> pready one cycle after access; o_sys_nrst low for 16 cycles;
//        CAUSE reads 0x5.
//  4. In RUN, lock drops one cycle.
//     -> all nrst low; full sequence repeats; CAUSE[3]=1.
//        Then W1C 0x08=0xF -> reads 0.
//  5. Lock toggles with period 6 (< lock_filter).
//     -> the block never leaves WAIT_LOCK; STATUS[10:8]=0.
//  6. i_nrst asserted mid-SYS_HOLD.
//     -> all outputs take reset values asynchronously; CAUSE=0x1.

Source files
------------

// File: rtl/prci_pkg.sv
// rtl/prci_pkg.sv - shared types, constants and register map for the PRCI reset sequencer
// Sequencing timings, state encoding, APB/PnP record types and CAUSE bit positions.
package prci_pkg;

  localparam int LOCK_FILTER     = 8;
  localparam int DBG_HOLD_CYCLES = 4;
  localparam int SYS_HOLD_CYCLES = 16;

  localparam logic [15:0] VENDOR_ID = 16'h00F1;
  localparam logic [15:0] DEVICE_ID = 16'h0A21;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    DBG_REL   = 3'd1,
    DDR_REL   = 3'd2,
    WAIT_CAL  = 3'd3,
    SYS_HOLD  = 3'd4,
    RUN       = 3'd5
  } state_t;

  // Word offsets, decoded from paddr[4:2]
  localparam logic [2:0] REG_STATUS = 3'd0;
  localparam logic [2:0] REG_SWRST  = 3'd1;
  localparam logic [2:0] REG_CAUSE  = 3'd2;

  localparam int CAUSE_POR     = 0;
  localparam int CAUSE_DMRESET = 1;
  localparam int CAUSE_SW      = 2;
  localparam int CAUSE_LOCK    = 3;

  typedef struct packed {
    logic [31:0] addr_start;
    logic [31:0] addr_mask;
  } mapinfo_type;

  typedef struct packed {
    logic [7:0]  descrsize;
    logic [1:0]  descrtype;
    logic [31:0] addr_start;
    logic [31:0] addr_end;
    logic [15:0] vid;
    logic [15:0] did;
  } dev_config_type;

  typedef struct packed {
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
  } apb_in_type;

  typedef struct packed {
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
  } apb_out_type;

endpackage

// File: rtl/prci_rst_seq_if.sv
// rtl/prci_rst_seq_if.sv - APB slot bundle between the PRCI bus and the reset sequencer
interface prci_rst_seq_if;
  import prci_pkg::*;

  apb_in_type  apbi;
  apb_out_type apbo;

  modport master (output apbi, input apbo);
  modport slave  (input apbi, output apbo);
endinterface

// File: rtl/prci_lock_filter.sv
// rtl/prci_lock_filter.sv - PLL lock synchroniser and debounce filter
// lock_ok rises after LOCK_FILTER consecutive high synced samples, drops on the first low one.
module prci_lock_filter
  import prci_pkg::*;
(
  input  logic clk,
  input  logic nrst,
  input  logic pll_locked,
  output logic lock_ok
);

  localparam int CW = $clog2(LOCK_FILTER);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q  <= 2'b00;
      cnt     <= '0;
      lock_ok <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
      if (!sync_q[1]) begin
        cnt     <= '0;
        lock_ok <= 1'b0;
      end else if (!lock_ok) begin
        if (cnt == CW'(LOCK_FILTER - 1)) begin
          lock_ok <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prci_rst_seq.sv
// rtl/prci_rst_seq.sv - SoC reset sequencer (debug, DDR, system) with PRCI APB register bank
// Registers are cleared only by i_nrst so they survive every sequenced reset.
module prci_rst_seq
  import prci_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_nrst,
  input  mapinfo_type    i_mapinfo,
  output dev_config_type o_cfg,
  prci_rst_seq_if.slave  apb,
  input  logic           i_pll_locked,
  input  logic           i_ddr_calib,
  input  logic           i_dmreset,
  output logic           o_dbg_nrst,
  output logic           o_ddr_nrst,
  output logic           o_sys_nrst
);

  logic        lock_ok;
  state_t      state, state_n;
  logic [4:0]  cnt, cnt_n;
  logic        dbg_n, ddr_n, sys_n;
  logic [3:0]  cause, cause_n, cause_set, cause_clr;
  logic        pready_q, pready_n;
  logic [31:0] prdata_q, prdata_n, rdata;
  logic        access, sw_req;
  logic [2:0]  reg_sel;

  prci_lock_filter u_lock_filter (
    .clk        (i_clk),
    .nrst       (i_nrst),
    .pll_locked (i_pll_locked),
    .lock_ok    (lock_ok)
  );

  assign o_cfg = '{
    descrsize:  8'd16,
    descrtype:  2'b10,
    addr_start: i_mapinfo.addr_start,
    addr_end:   i_mapinfo.addr_start | ~i_mapinfo.addr_mask,
    vid:        VENDOR_ID,
    did:        DEVICE_ID
  };

  assign apb.apbo = '{pready: pready_q, prdata: prdata_q, pslverr: 1'b0};

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    dbg_n     = o_dbg_nrst;
    ddr_n     = o_ddr_nrst;
    sys_n     = o_sys_nrst;
    cause_set = '0;
    cause_clr = '0;
    rdata     = '0;
    reg_sel   = apb.apbi.paddr[4:2];

    // The completing cycle has pready high; masking it keeps one access per transfer.
    access = apb.apbi.psel & apb.apbi.penable & ~pready_q;
    sw_req = access & apb.apbi.pwrite & (reg_sel == REG_SWRST) & apb.apbi.pwdata[0];
    if (access && apb.apbi.pwrite && reg_sel == REG_CAUSE) begin
      cause_clr = apb.apbi.pwdata[3:0];
    end
    if (sw_req) begin
      cause_set[CAUSE_SW] = 1'b1;
    end

    if (!lock_ok && state != WAIT_LOCK) begin
      state_n                = WAIT_LOCK;
      cnt_n                  = '0;
      dbg_n                  = 1'b0;
      ddr_n                  = 1'b0;
      sys_n                  = 1'b0;
      cause_set[CAUSE_LOCK]  = 1'b1;
    end else begin
      case (state)
        WAIT_LOCK: begin
          if (lock_ok) begin
            state_n = DBG_REL;
            cnt_n   = '0;
            dbg_n   = 1'b1;
          end
        end
        DBG_REL: begin
          if (cnt == 5'(DBG_HOLD_CYCLES - 1)) begin
            state_n = DDR_REL;
            cnt_n   = '0;
            ddr_n   = 1'b1;
          end else begin
            cnt_n = cnt + 5'd1;
          end
        end
        DDR_REL: state_n = WAIT_CAL;
        WAIT_CAL: begin
          if (i_ddr_calib) begin
            state_n = SYS_HOLD;
            cnt_n   = '0;
          end
        end
        SYS_HOLD: begin
          // A held ndmreset keeps restarting the hold window
          if (i_dmreset) begin
            cnt_n = '0;
          end else if (cnt == 5'(SYS_HOLD_CYCLES - 1)) begin
            state_n = RUN;
            cnt_n   = '0;
            sys_n   = 1'b1;
          end else begin
            cnt_n = cnt + 5'd1;
          end
        end
        RUN: begin
          if (i_dmreset || sw_req) begin
            state_n = SYS_HOLD;
            cnt_n   = '0;
            sys_n   = 1'b0;
            if (i_dmreset) begin
              cause_set[CAUSE_DMRESET] = 1'b1;
            end
          end
        end
        default: begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
          dbg_n   = 1'b0;
          ddr_n   = 1'b0;
          sys_n   = 1'b0;
        end
      endcase
    end

    // Hardware set wins over a simultaneous write-one-to-clear
    cause_n = (cause & ~cause_clr) | cause_set;

    case (reg_sel)
      REG_STATUS: begin
        rdata[0]    = lock_ok;
        rdata[1]    = i_ddr_calib;
        rdata[2]    = o_dbg_nrst;
        rdata[3]    = o_ddr_nrst;
        rdata[4]    = o_sys_nrst;
        rdata[10:8] = state;
      end
      REG_CAUSE: rdata[3:0] = cause;
      default:   rdata = '0;
    endcase

    pready_n = access;
    prdata_n = (access && !apb.apbi.pwrite) ? rdata : '0;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state      <= WAIT_LOCK;
      cnt        <= '0;
      o_dbg_nrst <= 1'b0;
      o_ddr_nrst <= 1'b0;
      o_sys_nrst <= 1'b0;
      cause      <= 4'b0001;
      pready_q   <= 1'b0;
      prdata_q   <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      o_dbg_nrst <= dbg_n;
      o_ddr_nrst <= ddr_n;
      o_sys_nrst <= sys_n;
      cause      <= cause_n;
      pready_q   <= pready_n;
      prdata_q   <= prdata_n;
    end
  end

endmodule

// File: tb/tb_prci_rst_seq.sv
// tb/tb_prci_rst_seq.sv - self-checking bench for the PRCI reset sequencer
module tb_prci_rst_seq;
  import prci_pkg::*;

  logic           clk = 1'b0;
  logic           nrst = 1'b0;
  logic           pll = 1'b0;
  logic           calib = 1'b0;
  logic           dm = 1'b0;
  logic           dbg_nrst, ddr_nrst, sys_nrst;
  mapinfo_type    mapinfo;
  dev_config_type cfg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];

  prci_rst_seq_if apb_if ();

  prci_rst_seq dut (
    .i_clk        (clk),
    .i_nrst       (nrst),
    .i_mapinfo    (mapinfo),
    .o_cfg        (cfg),
    .apb          (apb_if),
    .i_pll_locked (pll),
    .i_ddr_calib  (calib),
    .i_dmreset    (dm),
    .o_dbg_nrst   (dbg_nrst),
    .o_ddr_nrst   (ddr_nrst),
    .o_sys_nrst   (sys_nrst)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int ack_cyc);
    int n;
    apb_if.apbi = '{psel: 1'b1, penable: 1'b0, pwrite: wr, paddr: addr, pwdata: wdata};
    tick;
    apb_if.apbi.penable = 1'b1;
    n = 0;
    do begin
      tick;
      n++;
    end while (apb_if.apbo.pready !== 1'b1 && n < 8);
    ack_cyc = cyc;
    rdata   = apb_if.apbo.prdata;
    checks++;
    if (apb_if.apbo.pready !== 1'b1 || n != 1 || apb_if.apbo.pslverr !== 1'b0) begin
      errors++;
      $display("FAIL apb_wait_state: addr=%h waited %0d cycles pslverr=%b, required 1 cycle pslverr=0",
               addr, n, apb_if.apbo.pslverr);
    end
    apb_if.apbi = '0;
    tick;
    checks++;
    if (apb_if.apbo.pready !== 1'b0) begin
      errors++;
      $display("FAIL apb_pready_pulse: pready=%b two cycles after access, required 0", apb_if.apbo.pready);
    end
  endtask

  task automatic apb_read(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] got, want;
    int ack;
    exp_q.push_back(exp);
    apb_xfer(1'b0, addr, 32'h0, got, ack);
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: read %h, required %h", name, got, want);
    end
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, output int ack);
    logic [31:0] unused_rd;
    apb_xfer(1'b1, addr, data, unused_rd, ack);
  endtask

  task automatic test_reset;
    checks++;
    if ({dbg_nrst, ddr_nrst, sys_nrst} !== 3'b000 || apb_if.apbo !== '0) begin
      errors++;
      $display("FAIL reset_outputs: nrst=%b%b%b apbo=%h, required 000 and 0",
               dbg_nrst, ddr_nrst, sys_nrst, apb_if.apbo);
    end
    checks++;
    if (cfg.vid !== VENDOR_ID || cfg.did !== DEVICE_ID || cfg.addr_end !== 32'h0001_0FFF) begin
      errors++;
      $display("FAIL cfg: vid=%h did=%h end=%h, required %h %h 00010fff",
               cfg.vid, cfg.did, cfg.addr_end, VENDOR_ID, DEVICE_ID);
    end
  endtask

  task automatic test_por_sequence;
    int dbg_e = -1, ddr_e = -1, sys_e = -1;
    nrst = 1'b1;
    for (int e = 1; e <= 120 && sys_e < 0; e++) begin
      tick;
      if (e == 5)  pll = 1'b1;
      if (e == 40) calib = 1'b1;
      if (dbg_e < 0 && dbg_nrst) dbg_e = e;
      if (ddr_e < 0 && ddr_nrst) ddr_e = e;
      if (sys_e < 0 && sys_nrst) sys_e = e;
    end
    checks++;
    if (dbg_e != 16 || ddr_e != 20 || sys_e != 57) begin
      errors++;
      $display("FAIL por_release_cycles: dbg=%0d ddr=%0d sys=%0d, required 16 20 57", dbg_e, ddr_e, sys_e);
    end
    apb_read("por_cause", 32'h08, 32'h1);
    apb_read("run_status", 32'h00, 32'h51F);
  endtask

  task automatic test_dmreset;
    int fall, rel = -1, bad = 0, ack;
    tick;
    dm = 1'b1;
    tick;
    checks++;
    if ({dbg_nrst, ddr_nrst, sys_nrst} !== 3'b110) begin
      errors++;
      $display("FAIL dm_sys_low: nrst=%b%b%b, required 110", dbg_nrst, ddr_nrst, sys_nrst);
    end
    tick;
    tick;
    dm = 1'b0;
    fall = cyc;
    for (int n = 0; n < 40 && rel < 0; n++) begin
      tick;
      if (!dbg_nrst || !ddr_nrst) bad++;
      if (sys_nrst) rel = cyc;
    end
    checks++;
    if (rel - fall != 16 || bad != 0) begin
      errors++;
      $display("FAIL dm_release: %0d cycles after fall, dbg/ddr drops=%0d, required 16 and 0", rel - fall, bad);
    end
    apb_read("dm_cause", 32'h08, 32'h3);
    apb_write(32'h08, 32'h2, ack);
    apb_read("w1c_dm_cause", 32'h08, 32'h1);
  endtask

  task automatic test_sw_reset;
    int ack, rel = -1;
    apb_write(32'h04, 32'h1, ack);
    checks++;
    if (sys_nrst !== 1'b0) begin
      errors++;
      $display("FAIL sw_sys_low: sys_nrst=%b after SW request, required 0", sys_nrst);
    end
    for (int n = 0; n < 40 && rel < 0; n++) begin
      tick;
      if (sys_nrst) rel = cyc;
    end
    checks++;
    if (rel - ack != 16) begin
      errors++;
      $display("FAIL sw_release: sys high %0d cycles after access, required 16", rel - ack);
    end
    apb_read("sw_cause", 32'h08, 32'h5);
    apb_read("swrst_reads_zero", 32'h04, 32'h0);
    apb_read("unmapped_reads_zero", 32'h1C, 32'h0);
  endtask

  task automatic test_lock_loss;
    int base, loss = -1, dbg_e = -1, sys_e = -1, ack;
    logic all_low = 1'b0;
    tick;
    base = cyc;
    pll = 1'b0;
    tick;
    pll = 1'b1;
    for (int n = 0; n < 80 && sys_e < 0; n++) begin
      tick;
      if (loss < 0 && !sys_nrst) begin
        loss = cyc - base;
        all_low = !dbg_nrst && !ddr_nrst;
      end
      if (loss >= 0 && dbg_e < 0 && dbg_nrst) dbg_e = cyc - base;
      if (loss >= 0 && sys_e < 0 && sys_nrst) sys_e = cyc - base;
    end
    checks++;
    if (loss != 4 || !all_low || dbg_e != 12 || sys_e != 34) begin
      errors++;
      $display("FAIL lock_loss_sequence: loss=%0d all_low=%b dbg=%0d sys=%0d, required 4 1 12 34",
               loss, all_low, dbg_e, sys_e);
    end
    apb_read("lock_cause", 32'h08, 32'hD);
    apb_write(32'h08, 32'hF, ack);
    apb_read("w1c_all_cause", 32'h08, 32'h0);
  endtask

  task automatic test_lock_chatter;
    int bad = 0, ack;
    nrst = 1'b0;
    pll = 1'b0;
    tick;
    nrst = 1'b1;
    for (int i = 0; i < 90; i++) begin
      pll = ((i / 3) % 2) == 0;
      tick;
      if (dbg_nrst) bad++;
    end
    pll = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL chatter_no_release: dbg released %0d cycles, required 0", bad);
    end
    tick;
    tick;
    tick;
    apb_read("chatter_status", 32'h00, 32'h2);
    apb_write(32'h04, 32'h1, ack);
    apb_read("sw_outside_run_cause", 32'h08, 32'h5);
    apb_read("sw_outside_run_status", 32'h00, 32'h2);
  endtask

  task automatic test_async_reset;
    int n = 0;
    nrst = 1'b0;
    tick;
    nrst = 1'b1;
    pll = 1'b1;
    while (!ddr_nrst && n < 60) begin
      tick;
      n++;
    end
    repeat (5) tick;
    checks++;
    if ({dbg_nrst, ddr_nrst, sys_nrst} !== 3'b110) begin
      errors++;
      $display("FAIL pre_reset_sys_hold: nrst=%b%b%b, required 110", dbg_nrst, ddr_nrst, sys_nrst);
    end
    #3;
    nrst = 1'b0;
    #1;
    checks++;
    if ({dbg_nrst, ddr_nrst, sys_nrst} !== 3'b000 || apb_if.apbo !== '0) begin
      errors++;
      $display("FAIL async_reset: nrst=%b%b%b apbo=%h, required 000 and 0",
               dbg_nrst, ddr_nrst, sys_nrst, apb_if.apbo);
    end
    tick;
    nrst = 1'b1;
    apb_read("async_reset_cause", 32'h08, 32'h1);
    apb_read("async_reset_status", 32'h00, 32'h2);
  endtask

  initial begin
    mapinfo = '{addr_start: 32'h0001_0000, addr_mask: 32'hFFFF_F000};
    apb_if.apbi = '0;
    repeat (3) tick;
    test_reset;
    test_por_sequence;
    test_dmreset;
    test_sw_reset;
    test_lock_loss;
    test_lock_chatter;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
